matrix_result_unloader: RTL and testbench

//  Unload side of the matrix-multiply datapath. The load controller fills the operand

---
 rtl/matrix_result_unloader.sv | 124 ++++++++++++
 tb/tb_matrix_result_unloader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/matrix_result_unloader.sv
// matrix_result_unloader: snapshots the result bank and streams it out word by word
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high
//   start          request an unload (sampled in IDLE only)
//   abort          synchronous cancel of an unload in progress
//   results_in     flattened result bank, word i at [i*DATA_W +: DATA_W]
//   out_ready      downstream accepts dout this cycle
//   dout           current result word
//   dout_valid     dout / dout_idx are valid
//   dout_idx       index of the word on dout
//   final_mux_sel  result-mux select, always equal to dout_idx
//   busy           high in SEND and DONE
//   done           one-cycle pulse after the last word is accepted
//   mem_clr        one-cycle pulse clearing the result memory
module matrix_result_unloader #(
    parameter int DATA_W      = 16,
    parameter int NUM_RES     = 9,
    parameter int SEL_W       = 4,
    parameter int CLR_ON_DONE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_RES*DATA_W-1:0] results_in,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         dout,
    output logic                      dout_valid,
    output logic [SEL_W-1:0]          dout_idx,
    output logic [SEL_W-1:0]          final_mux_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_clr
);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_RES - 1);

    state_t             state, state_n;
    logic [DATA_W-1:0]  snap [NUM_RES];
    logic [SEL_W-1:0]   idx_n;
    logic [DATA_W-1:0]  dout_n;
    logic               valid_n, done_n, clr_n, busy_n, cap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            dout          <= '0;
            dout_valid    <= 1'b0;
            dout_idx      <= '0;
            final_mux_sel <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_clr       <= 1'b0;
            for (int i = 0; i < NUM_RES; i++) snap[i] <= '0;
        end else begin
            state         <= state_n;
            dout          <= dout_n;
            dout_valid    <= valid_n;
            dout_idx      <= idx_n;
            final_mux_sel <= idx_n;
            busy          <= busy_n;
            done          <= done_n;
            mem_clr       <= clr_n;
            if (cap) for (int i = 0; i < NUM_RES; i++) snap[i] <= results_in[i*DATA_W +: DATA_W];
        end
    end

    // The word for the first beat comes straight from results_in because the
    // snapshot is only written on the same edge.
    always_comb begin
        state_n = state;
        idx_n   = dout_idx;
        dout_n  = dout;
        valid_n = dout_valid;
        done_n  = 1'b0;
        clr_n   = 1'b0;
        cap     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = SEND;
                    idx_n   = '0;
                    dout_n  = results_in[DATA_W-1:0];
                    valid_n = 1'b1;
                    cap     = 1'b1;
                end
            end
            SEND: begin
                if (abort) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    dout_n  = '0;
                    valid_n = 1'b0;
                    clr_n   = 1'b1;
                end else if (out_ready) begin
                    if (dout_idx == LAST) begin
                        state_n = DONE;
                        idx_n   = '0;
                        dout_n  = '0;
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                        clr_n   = (CLR_ON_DONE != 0);
                    end else begin
                        idx_n  = dout_idx + 1'b1;
                        dout_n = snap[idx_n];
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                dout_n  = '0;
                valid_n = 1'b0;
            end
        endcase
        busy_n = (state_n == SEND) || (state_n == DONE);
    end
endmodule

// File: tb/tb_matrix_result_unloader.sv
// tb_matrix_result_unloader: directed checks of the result unloader
module tb_matrix_result_unloader;
    logic         clk = 0, reset = 1;
    logic         start = 0, abort = 0, out_ready = 1;
    logic         start0 = 0, abort0 = 0, out_ready0 = 1;
    logic [143:0] results_in = '0;
    logic [15:0]  dout, dout0;
    logic         dout_valid, busy, done, mem_clr;
    logic         dout_valid0, busy0, done0, mem_clr0;
    logic [3:0]   dout_idx, final_mux_sel, dout_idx0, final_mux_sel0;
    int           total = 0, passed = 0;

    always #5 clk = ~clk;

    matrix_result_unloader #(.DATA_W(16), .NUM_RES(9), .SEL_W(4), .CLR_ON_DONE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .results_in(results_in),
        .out_ready(out_ready), .dout(dout), .dout_valid(dout_valid), .dout_idx(dout_idx),
        .final_mux_sel(final_mux_sel), .busy(busy), .done(done), .mem_clr(mem_clr)
    );

    matrix_result_unloader #(.DATA_W(16), .NUM_RES(9), .SEL_W(4), .CLR_ON_DONE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0), .results_in(results_in),
        .out_ready(out_ready0), .dout(dout0), .dout_valid(dout_valid0), .dout_idx(dout_idx0),
        .final_mux_sel(final_mux_sel0), .busy(busy0), .done(done0), .mem_clr(mem_clr0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic load_bank();
        for (int i = 0; i < 9; i++) results_in[i*16 +: 16] = 16'(i + 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, dout_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // One full unload of words 1..9; toggle applies the ready pattern 1,0,0,1,
    // corrupt overwrites the bank after capture and pulses start mid-unload.
    task automatic unload(input bit toggle, input bit corrupt);
        int k = 0;
        int c = 0;
        bit rdy;
        @(negedge clk);
        start = 1;
        out_ready = 1;
        @(negedge clk);
        start = 0;
        if (corrupt) results_in = '1;
        while (k < 9 && c < 60) begin
            check("word_valid", dout_valid, 1);
            check("word_data", dout, 32'(k + 1));
            check("word_idx", dout_idx, 32'(k));
            check("word_sel", final_mux_sel, 32'(k));
            check("word_done", done, 0);
            start = corrupt && c == 3;
            rdy = toggle ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            out_ready = rdy;
            @(negedge clk);
            if (rdy) k++;
            c++;
        end
        start = 0;
        check("transfers", 32'(k), 9);
        check("end_valid", dout_valid, 0);
        check("end_done", done, 1);
        check("end_clr", mem_clr, 1);
        check("end_busy", busy, 1);
        @(negedge clk);
        check_idle("after_done");
        check("after_clr", mem_clr, 0);
        if (corrupt) load_bank();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        load_bank();
        #2;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_idx", dout_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clr", mem_clr, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        check_idle("idle");

        unload(0, 0);
        unload(1, 0);
        unload(0, 1);

        // abort while word 4 is on the bus
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        check("abort_idx", dout_idx, 4);
        check("abort_data", dout, 5);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check_idle("abort");
        check("abort_clr", mem_clr, 1);
        @(negedge clk);
        check("abort_clr_end", mem_clr, 0);
        check_idle("abort_idle");

        // asynchronous reset at word 6
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (6) @(negedge clk);
        check("pre_rst_idx", dout_idx, 6);
        #2 reset = 1;
        #1;
        check("arst_dout", dout, 0);
        check("arst_valid", dout_valid, 0);
        check("arst_idx", dout_idx, 0);
        check("arst_sel", final_mux_sel, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_clr", mem_clr, 0);
        @(negedge clk);
        reset = 0;
        unload(0, 0);

        // no mem_clr on completion, start held high: back-to-back unloads
        @(negedge clk);
        start0 = 1;
        begin
            int dones = 0;
            for (int c = 1; c <= 22; c++) begin
                @(negedge clk);
                check("b2b_valid", dout_valid0, 32'((c - 1) % 11 < 9));
                check("b2b_done", done0, 32'((c - 1) % 11 == 9));
                check("b2b_clr", mem_clr0, 0);
                if ((c - 1) % 11 < 9) check("b2b_data", dout0, 32'((c - 1) % 11 + 1));
                if (done0) dones++;
            end
            start0 = 0;
            check("b2b_dones", 32'(dones), 2);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
